// File: rtl/pe_tx_scheduler_pkg.sv
// Shared types and helpers for the PE transmit scheduler: FSM state encoding
// and pointer width derivation.
package pe_tx_scheduler_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_SCAN = 2'd1,
      ST_SEND = 2'd2,
      ST_DONE = 2'd3
   } tx_state_e;

   localparam int unsigned MAX_CH = 8;

   // Width of a channel index; kept at least 1 so a single-channel build stays legal.
   function automatic int unsigned ptr_width(input int unsigned n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/pe_tx_scheduler_rr_arbiter.sv
// Round-robin arbiter: picks the first requesting channel at or after ptr,
// returning both a one-hot grant and its index.
module pe_tx_rr_arbiter #(
   parameter int unsigned NUM_CH = 2,
   parameter int unsigned PW     = 1
) (
   input  logic [NUM_CH-1:0] req,
   input  logic [PW-1:0]     ptr,
   output logic [NUM_CH-1:0] gnt,
   output logic [PW-1:0]     gnt_idx,
   output logic              gnt_vld
);

   int unsigned cand;
   logic        found;

   always_comb begin
      gnt     = '0;
      gnt_idx = '0;
      found   = 1'b0;
      cand    = 0;
      for (int unsigned i = 0; i < NUM_CH; i++) begin
         cand = (32'(ptr) + i) % NUM_CH;
         if (!found && req[cand]) begin
            found     = 1'b1;
            gnt[cand] = 1'b1;
            gnt_idx   = PW'(cand);
         end
      end
      gnt_vld = found;
   end

endmodule

// File: rtl/pe_tx_scheduler.sv
// Multi-channel send engine: scans regfile ranges per job, optionally skipping
// zero entries, and streams flits onto one router port with round-robin job grant.
module pe_tx_scheduler
   import pe_tx_scheduler_pkg::*;
#(
   parameter int unsigned NUM_CH     = 2,
   parameter int unsigned DATA_W     = 16,
   parameter int unsigned ACT_ADDR_W = 6,
   parameter int unsigned RADDR_W    = 4
) (
   input  logic                               clk,
   input  logic                               rst,
   input  logic [NUM_CH-1:0]                  ch_start,
   input  logic [NUM_CH*ACT_ADDR_W-1:0]       ch_base,
   input  logic [NUM_CH*(ACT_ADDR_W+1)-1:0]   ch_cnt,
   input  logic [NUM_CH*RADDR_W-1:0]          ch_dest,
   input  logic [NUM_CH-1:0]                  ch_skip0,
   output logic [NUM_CH-1:0]                  ch_busy,
   output logic [NUM_CH-1:0]                  ch_done,
   input  logic [(2**ACT_ADDR_W)-1:0]         act_zeros,
   input  logic                               comp_read_en,
   input  logic [ACT_ADDR_W-1:0]              comp_read_addr,
   output logic                               rf_read_en,
   output logic [ACT_ADDR_W-1:0]              rf_read_addr,
   input  logic [DATA_W-1:0]                  rf_read_data,
   input  logic                               router_rdy,
   output logic                               send_en,
   output logic [RADDR_W-1:0]                 send_addr,
   output logic [DATA_W-1:0]                  send_data,
   output logic [ACT_ADDR_W-1:0]              send_idx
);

   localparam int unsigned CW = ACT_ADDR_W + 1;
   localparam int unsigned PW = ptr_width(NUM_CH);

   logic [NUM_CH-1:0]     pending;
   logic [ACT_ADDR_W-1:0] d_base [NUM_CH];
   logic [CW-1:0]         d_cnt  [NUM_CH];
   logic [RADDR_W-1:0]    d_dest [NUM_CH];
   logic [NUM_CH-1:0]     d_skip;

   tx_state_e             state;
   logic [PW-1:0]         cur;
   logic [PW-1:0]         ptr;
   logic [ACT_ADDR_W-1:0] idx;
   logic [CW-1:0]         rem;
   logic [RADDR_W-1:0]    job_dest;
   logic                  job_skip;
   logic [DATA_W-1:0]     data_hold;
   logic                  fresh;

   logic [NUM_CH-1:0]     gnt;
   logic [PW-1:0]         gnt_idx;
   logic                  gnt_vld;
   logic                  scan_zero;
   logic                  sched_rd;

   pe_tx_rr_arbiter #(
      .NUM_CH (NUM_CH),
      .PW     (PW)
   ) u_arb (
      .req     (pending),
      .ptr     (ptr),
      .gnt     (gnt),
      .gnt_idx (gnt_idx),
      .gnt_vld (gnt_vld)
   );

   // A start on a channel that is still pending/active is dropped.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pending <= '0;
         d_skip  <= '0;
         for (int unsigned i = 0; i < NUM_CH; i++) begin
            d_base[i] <= '0;
            d_cnt[i]  <= '0;
            d_dest[i] <= '0;
         end
      end else begin
         for (int unsigned i = 0; i < NUM_CH; i++) begin
            if (state == ST_DONE && cur == PW'(i)) begin
               pending[i] <= 1'b0;
            end else if (ch_start[i] && !pending[i]) begin
               pending[i] <= 1'b1;
               d_base[i]  <= ch_base[i*ACT_ADDR_W +: ACT_ADDR_W];
               d_cnt[i]   <= ch_cnt[i*CW +: CW];
               d_dest[i]  <= ch_dest[i*RADDR_W +: RADDR_W];
               d_skip[i]  <= ch_skip0[i];
            end
         end
      end
   end

   assign scan_zero = job_skip && act_zeros[idx];
   assign sched_rd  = (state == ST_SCAN) && (rem != '0) && !scan_zero && !comp_read_en;

   // The last consumed entry jumps straight to DONE so the done pulse follows the final flit.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= ST_IDLE;
         cur       <= '0;
         ptr       <= '0;
         idx       <= '0;
         rem       <= '0;
         job_dest  <= '0;
         job_skip  <= 1'b0;
         data_hold <= '0;
         fresh     <= 1'b0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (gnt_vld) begin
                  cur      <= gnt_idx;
                  idx      <= d_base[gnt_idx];
                  rem      <= d_cnt[gnt_idx];
                  job_dest <= d_dest[gnt_idx];
                  job_skip <= d_skip[gnt_idx];
                  ptr      <= (gnt_idx == PW'(NUM_CH - 1)) ? '0 : gnt_idx + PW'(1);
                  state    <= ST_SCAN;
               end
            end
            ST_SCAN: begin
               if (rem == '0) begin
                  state <= ST_DONE;
               end else if (scan_zero) begin
                  idx <= idx + ACT_ADDR_W'(1);
                  rem <= rem - CW'(1);
                  if (rem == CW'(1)) state <= ST_DONE;
               end else if (!comp_read_en) begin
                  fresh <= 1'b1;
                  state <= ST_SEND;
               end
            end
            ST_SEND: begin
               if (fresh) begin
                  data_hold <= rf_read_data;
                  fresh     <= 1'b0;
               end
               if (router_rdy) begin
                  idx   <= idx + ACT_ADDR_W'(1);
                  rem   <= rem - CW'(1);
                  state <= (rem == CW'(1)) ? ST_DONE : ST_SCAN;
               end
            end
            ST_DONE: begin
               state <= ST_IDLE;
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

   always_comb begin
      ch_done = '0;
      if (state == ST_DONE) ch_done[cur] = 1'b1;
   end

   assign ch_busy      = pending;
   assign rf_read_en   = comp_read_en | sched_rd;
   assign rf_read_addr = comp_read_en ? comp_read_addr : (sched_rd ? idx : '0);

   // Read data is live in the first SEND cycle and taken from the hold register afterwards.
   assign send_en   = (state == ST_SEND) && router_rdy;
   assign send_addr = (state == ST_SEND) ? job_dest : '0;
   assign send_idx  = (state == ST_SEND) ? idx : '0;
   assign send_data = (state != ST_SEND) ? '0 : (fresh ? rf_read_data : data_hold);

endmodule

// File: tb/tb_pe_tx_scheduler.sv
// Scoreboard bench for pe_tx_scheduler: expected flits queued at job start,
// compared as the DUT sends them; per-scenario tasks check timing and done pulses.
module tb_pe_tx_scheduler;

   localparam int NUM_CH = 2;
   localparam int DW     = 16;
   localparam int AW     = 6;
   localparam int RW     = 4;
   localparam int ACT_NO = 64;

   logic                     clk;
   logic                     rst;
   logic [NUM_CH-1:0]        ch_start;
   logic [NUM_CH*AW-1:0]     ch_base;
   logic [NUM_CH*(AW+1)-1:0] ch_cnt;
   logic [NUM_CH*RW-1:0]     ch_dest;
   logic [NUM_CH-1:0]        ch_skip0;
   logic [NUM_CH-1:0]        ch_busy;
   logic [NUM_CH-1:0]        ch_done;
   logic [ACT_NO-1:0]        act_zeros;
   logic                     comp_read_en;
   logic [AW-1:0]            comp_read_addr;
   logic                     rf_read_en;
   logic [AW-1:0]            rf_read_addr;
   logic [DW-1:0]            rf_read_data;
   logic                     router_rdy;
   logic                     send_en;
   logic [RW-1:0]            send_addr;
   logic [DW-1:0]            send_data;
   logic [AW-1:0]            send_idx;

   pe_tx_scheduler #(
      .NUM_CH     (NUM_CH),
      .DATA_W     (DW),
      .ACT_ADDR_W (AW),
      .RADDR_W    (RW)
   ) dut (
      .clk            (clk),
      .rst            (rst),
      .ch_start       (ch_start),
      .ch_base        (ch_base),
      .ch_cnt         (ch_cnt),
      .ch_dest        (ch_dest),
      .ch_skip0       (ch_skip0),
      .ch_busy        (ch_busy),
      .ch_done        (ch_done),
      .act_zeros      (act_zeros),
      .comp_read_en   (comp_read_en),
      .comp_read_addr (comp_read_addr),
      .rf_read_en     (rf_read_en),
      .rf_read_addr   (rf_read_addr),
      .rf_read_data   (rf_read_data),
      .router_rdy     (router_rdy),
      .send_en        (send_en),
      .send_addr      (send_addr),
      .send_data      (send_data),
      .send_idx       (send_idx)
   );

   typedef struct {
      int          idx;
      int          addr;
      logic [DW-1:0] data;
      int          cyc;
   } flit_t;

   flit_t         sb[$];
   flit_t         mon_e;
   logic [DW-1:0] mem [ACT_NO];
   int            cyc;
   int            errors;
   int            checks;
   int            done_cnt [NUM_CH];
   int            done_cyc [NUM_CH];
   int            d_base [NUM_CH];
   int            d_cnt  [NUM_CH];
   int            d_dest [NUM_CH];
   bit            d_skip [NUM_CH];
   int            tb_ptr;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // Regfile model: one-cycle read latency.
   always @(posedge clk) if (rf_read_en) rf_read_data <= mem[rf_read_addr];

   always @(negedge clk) begin
      if (!rst) begin
         if (send_en) begin
            if (!router_rdy) begin
               checks++; errors++;
               $display("FAIL send_without_rdy cyc=%0d send_en=1 router_rdy=0", cyc);
            end
            if (sb.size() == 0) begin
               checks++; errors++;
               $display("FAIL unexpected_flit cyc=%0d idx=%0d addr=%0d required no flit", cyc, send_idx, send_addr);
            end else begin
               mon_e = sb.pop_front();
               checks++;
               if (send_idx !== AW'(mon_e.idx)) begin
                  errors++;
                  $display("FAIL flit_idx cyc=%0d got=%0d exp=%0d", cyc, send_idx, mon_e.idx);
               end
               checks++;
               if (send_addr !== RW'(mon_e.addr)) begin
                  errors++;
                  $display("FAIL flit_addr cyc=%0d got=%0d exp=%0d", cyc, send_addr, mon_e.addr);
               end
               checks++;
               if (send_data !== mon_e.data) begin
                  errors++;
                  $display("FAIL flit_data cyc=%0d got=%h exp=%h", cyc, send_data, mon_e.data);
               end
               if (mon_e.cyc >= 0) begin
                  checks++;
                  if (cyc != mon_e.cyc) begin
                     errors++;
                     $display("FAIL flit_cycle idx=%0d got=%0d exp=%0d", mon_e.idx, cyc, mon_e.cyc);
                  end
               end
            end
         end
         if (ch_done != '0) begin
            checks++;
            if ($countones(ch_done) != 1) begin
               errors++;
               $display("FAIL done_onehot cyc=%0d got=%b exp=one-hot", cyc, ch_done);
            end
            for (int c = 0; c < NUM_CH; c++) begin
               if (ch_done[c]) begin
                  done_cnt[c]++;
                  done_cyc[c] = cyc;
               end
            end
         end
      end
   end

   task automatic set_desc(input int ch, input int base, input int cnt, input int dest, input bit skip);
      ch_base[ch*AW +: AW]         = AW'(base);
      ch_cnt[ch*(AW+1) +: (AW+1)]  = (AW+1)'(cnt);
      ch_dest[ch*RW +: RW]         = RW'(dest);
      ch_skip0[ch]                 = skip;
      d_base[ch] = base;
      d_cnt[ch]  = cnt;
      d_dest[ch] = dest;
      d_skip[ch] = skip;
   endtask

   // Expected flits of a job, in service order; first_cyc >= 0 pins a 2-cycle cadence.
   task automatic push_expect(input int ch, input int first_cyc);
      flit_t f;
      int    i;
      int    n;
      n = 0;
      for (int k = 0; k < d_cnt[ch]; k++) begin
         i = (d_base[ch] + k) % ACT_NO;
         if (!(d_skip[ch] && act_zeros[i])) begin
            f.idx  = i;
            f.addr = d_dest[ch];
            f.data = mem[i];
            f.cyc  = (first_cyc >= 0) ? first_cyc + 2 * n : -1;
            sb.push_back(f);
            n++;
         end
      end
   endtask

   task automatic pulse(input logic [NUM_CH-1:0] mask, output int t);
      t = cyc;
      ch_start = mask;
      @(negedge clk);
      ch_start = '0;
   endtask

   task automatic wait_drain(input int limit, input string name);
      int n;
      n = 0;
      while ((ch_busy != '0 || sb.size() != 0) && n < limit) begin
         @(negedge clk);
         n++;
      end
      checks++;
      if (n >= limit) begin
         errors++;
         $display("FAIL %s_timeout busy=%b queued=%0d required idle within %0d cycles", name, ch_busy, sb.size(), limit);
      end
      @(negedge clk);
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (3) @(negedge clk);
      checks++;
      if ({ch_busy, ch_done, send_en, rf_read_en} !== '0) begin
         errors++;
         $display("FAIL reset_ctrl got=%b exp=0", {ch_busy, ch_done, send_en, rf_read_en});
      end
      checks++;
      if ({send_addr, send_data, send_idx, rf_read_addr} !== '0) begin
         errors++;
         $display("FAIL reset_data got=%h exp=0", {send_addr, send_data, send_idx, rf_read_addr});
      end
      rst = 1'b0;
      tb_ptr = 0;
      @(negedge clk);
   endtask

   task automatic test_latency();
      int t;
      int dc;
      dc = done_cnt[0];
      set_desc(0, 4, 3, 5, 1'b0);
      pulse(2'b01, t);
      push_expect(0, t + 3);
      tb_ptr = 1;
      checks++;
      if (ch_busy !== 2'b01) begin
         errors++;
         $display("FAIL latency_busy got=%b exp=01", ch_busy);
      end
      @(negedge clk);
      checks++;
      if (rf_read_en !== 1'b1 || rf_read_addr !== AW'(4)) begin
         errors++;
         $display("FAIL latency_read got=en%b/addr%0d exp=en1/addr4", rf_read_en, rf_read_addr);
      end
      wait_drain(100, "latency");
      checks++;
      if (done_cnt[0] != dc + 1 || done_cyc[0] != t + 8) begin
         errors++;
         $display("FAIL latency_done got=n%0d@%0d exp=n%0d@%0d", done_cnt[0], done_cyc[0], dc + 1, t + 8);
      end
   endtask

   task automatic test_round_robin();
      int t;
      int first;
      int solo;
      int dc0;
      int dc1;
      for (int r = 0; r < 2; r++) begin
         solo = (r == 0) ? 1 : 0;
         set_desc(solo, 10 + r, 1, 9, 1'b0);
         pulse(NUM_CH'(1 << solo), t);
         push_expect(solo, -1);
         tb_ptr = (solo + 1) % NUM_CH;
         wait_drain(100, "rr_solo");
         dc0 = done_cnt[0];
         dc1 = done_cnt[1];
         set_desc(0, 12, 2, 3, 1'b0);
         set_desc(1, 16, 2, 11, 1'b0);
         pulse(2'b11, t);
         checks++;
         if (ch_busy !== 2'b11) begin
            errors++;
            $display("FAIL rr_busy got=%b exp=11", ch_busy);
         end
         first = tb_ptr;
         push_expect(first, -1);
         push_expect(1 - first, -1);
         tb_ptr = first;
         wait_drain(100, "rr_pair");
         checks++;
         if (done_cnt[0] != dc0 + 1 || done_cnt[1] != dc1 + 1) begin
            errors++;
            $display("FAIL rr_done got=%0d/%0d exp=%0d/%0d", done_cnt[0], done_cnt[1], dc0 + 1, dc1 + 1);
         end
      end
   endtask

   task automatic test_back_to_back();
      int t;
      int t2;
      int dc0;
      dc0 = done_cnt[0];
      set_desc(0, 40, 2, 7, 1'b0);
      pulse(2'b01, t);
      push_expect(0, -1);
      ch_base[0 +: AW]    = AW'(50);
      ch_cnt[0 +: (AW+1)] = (AW+1)'(1);
      set_desc(1, 44, 2, 2, 1'b0);
      pulse(2'b11, t2);
      push_expect(1, -1);
      tb_ptr = 0;
      wait_drain(100, "b2b");
      checks++;
      if (done_cnt[0] != dc0 + 1) begin
         errors++;
         $display("FAIL b2b_ignored_start got=%0d exp=%0d", done_cnt[0], dc0 + 1);
      end
   endtask

   task automatic test_skip();
      int t;
      int dc;
      act_zeros = '0;
      act_zeros[1] = 1'b1;
      act_zeros[2] = 1'b1;
      for (int k = 8; k < 12; k++) act_zeros[k] = 1'b1;
      dc = done_cnt[0];
      set_desc(0, 0, 4, 6, 1'b1);
      pulse(2'b01, t);
      push_expect(0, -1);
      tb_ptr = 1;
      wait_drain(100, "skip");
      checks++;
      if (done_cnt[0] != dc + 1) begin
         errors++;
         $display("FAIL skip_done got=%0d exp=%0d", done_cnt[0], dc + 1);
      end
      dc = done_cnt[1];
      set_desc(1, 8, 4, 4, 1'b1);
      pulse(2'b10, t);
      push_expect(1, -1);
      tb_ptr = 0;
      wait_drain(100, "allzero");
      checks++;
      if (done_cnt[1] != dc + 1 || done_cyc[1] != t + 6) begin
         errors++;
         $display("FAIL allzero_done got=n%0d@%0d exp=n%0d@%0d", done_cnt[1], done_cyc[1], dc + 1, t + 6);
      end
      set_desc(0, 0, 4, 6, 1'b0);
      pulse(2'b01, t);
      push_expect(0, -1);
      tb_ptr = 1;
      wait_drain(100, "noskip");
      act_zeros = '0;
   endtask

   task automatic test_comp_stall();
      int t;
      set_desc(0, 20, 3, 1, 1'b0);
      pulse(2'b01, t);
      push_expect(0, -1);
      tb_ptr = 1;
      comp_read_en   = 1'b1;
      comp_read_addr = AW'(50);
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         checks++;
         if (rf_read_en !== 1'b1 || rf_read_addr !== AW'(50) || send_en !== 1'b0) begin
            errors++;
            $display("FAIL comp_priority k=%0d got=en%b/addr%0d/send%b exp=en1/addr50/send0", k, rf_read_en, rf_read_addr, send_en);
         end
      end
      comp_read_en = 1'b0;
      wait_drain(100, "comp");
   endtask

   task automatic test_router_stall();
      int t;
      router_rdy = 1'b0;
      set_desc(1, 30, 2, 13, 1'b0);
      pulse(2'b10, t);
      push_expect(1, -1);
      tb_ptr = 0;
      @(negedge clk);
      @(negedge clk);
      comp_read_en   = 1'b1;
      comp_read_addr = AW'(60);
      for (int k = 0; k < 10; k++) begin
         checks++;
         if (send_en !== 1'b0 || send_idx !== AW'(30) || send_addr !== RW'(13) || send_data !== mem[30]) begin
            errors++;
            $display("FAIL router_hold k=%0d got=%b/%0d/%0d/%h exp=0/30/13/%h", k, send_en, send_idx, send_addr, send_data, mem[30]);
         end
         @(negedge clk);
         comp_read_en = 1'b0;
      end
      router_rdy = 1'b1;
      wait_drain(100, "router");
   endtask

   task automatic test_wrap_and_bounds();
      int t;
      int dc;
      set_desc(0, 62, 4, 15, 1'b0);
      pulse(2'b01, t);
      push_expect(0, -1);
      tb_ptr = 1;
      wait_drain(100, "wrap");
      set_desc(1, 10, ACT_NO, 8, 1'b0);
      pulse(2'b10, t);
      push_expect(1, -1);
      tb_ptr = 0;
      wait_drain(400, "full");
      dc = done_cnt[0];
      set_desc(0, 33, 0, 2, 1'b0);
      pulse(2'b01, t);
      tb_ptr = 1;
      wait_drain(100, "cnt0");
      checks++;
      if (done_cnt[0] != dc + 1 || done_cyc[0] != t + 3) begin
         errors++;
         $display("FAIL cnt0_done got=n%0d@%0d exp=n%0d@%0d", done_cnt[0], done_cyc[0], dc + 1, t + 3);
      end
   endtask

   task automatic test_reset_mid();
      int t;
      int dc;
      dc = done_cnt[0];
      set_desc(0, 0, 10, 3, 1'b0);
      pulse(2'b01, t);
      push_expect(0, -1);
      repeat (6) @(negedge clk);
      rst = 1'b1;
      sb.delete();
      @(negedge clk);
      checks++;
      if (ch_busy !== '0 || send_en !== 1'b0 || rf_read_en !== 1'b0) begin
         errors++;
         $display("FAIL midreset_clear got=busy%b/send%b/rd%b exp=0", ch_busy, send_en, rf_read_en);
      end
      rst = 1'b0;
      tb_ptr = 0;
      repeat (30) @(negedge clk);
      checks++;
      if (done_cnt[0] != dc) begin
         errors++;
         $display("FAIL midreset_done got=%0d exp=%0d", done_cnt[0], dc);
      end
   endtask

   initial begin
      errors = 0;
      checks = 0;
      tb_ptr = 0;
      for (int c = 0; c < NUM_CH; c++) begin
         done_cnt[c] = 0;
         done_cyc[c] = -1;
      end
      for (int i = 0; i < ACT_NO; i++) mem[i] = {8'(i * 7 + 3), ~8'(i)};
      rst            = 1'b1;
      ch_start       = '0;
      ch_base        = '0;
      ch_cnt         = '0;
      ch_dest        = '0;
      ch_skip0       = '0;
      act_zeros      = '0;
      comp_read_en   = 1'b0;
      comp_read_addr = '0;
      router_rdy     = 1'b1;
      rf_read_data   = '0;
      @(negedge clk);
      test_reset();
      test_latency();
      test_round_robin();
      test_back_to_back();
      test_skip();
      test_comp_stall();
      test_router_stall();
      test_wrap_and_bounds();
      test_reset_mid();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL global_timeout cyc=%0d required completion", cyc);
      $fatal(1, "timeout");
   end

endmodule
